fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current word address pc[31:2] and issues one instruction-memory request at a time. Buffers returned {pc, instr} pairs in a DEPTH-entry FIFO and presents them to the ID stage over a valid/ready handshake.
- Signals upstream when the current PC has been consumed, so next-PC logic knows when to advance.
- A flush (branch/jump redirect) empties the queue and discards any in-flight response.

Parameters:
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- pc_i  in  30  current PC word address [31:2] from the PC register.
- pc_adv  out  1  PC accepted this cycle; upstream loads NPC = PC+1 word (or redirect target).
- flush  in  1  redirect: clear queue, drop outstanding response.
- imem_req  out  1  fetch request.
- imem_addr  out  30  request word address (= pc_i).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  queue head valid.
- id_instr  out  32  head instruction.
- id_pc  out  30  head PC word address.
- id_ready  in  1  ID consumes head when id_valid & id_ready.

Behaviour:
- Reset (rst=0, async): queue empty, count=0, state=IDLE, drop flag clear.
  - id_valid=0, id_instr=0, id_pc=0, imem_req=0, pc_adv=0.
- States:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding, response kept.
  - DROP: one request outstanding, response discarded.
- imem_req (combinational) = (state==IDLE) & (count < DEPTH) & ~flush & rst.
- imem_addr = pc_i.
- pc_adv = imem_req & imem_gnt.
- The pc_i value is latched into an internal req_pc register on pc_adv.
- Transitions:
  - IDLE→WAIT on pc_adv.
  - WAIT→IDLE on imem_rvalid & ~flush; push {req_pc, imem_rdata}.
  - WAIT→DROP on flush & ~imem_rvalid.
  - WAIT→IDLE on flush & imem_rvalid; response discarded.
  - DROP→IDLE on imem_rvalid; response discarded. Flush in DROP keeps DROP.
- Space rule: a request is issued only when count < DEPTH. Because only one request is outstanding, a response always has a free slot, so no overflow is possible.
- Latency:
  - pc_adv in cycle N; earliest rvalid in cycle N+1.
  - Entry visible at id_valid in cycle N+2 (registered FIFO).
  - No reissue in the rvalid cycle, so peak throughput is 1 instruction per 2 cycles at 1-cycle memory latency.
- FIFO:
  - Pop on id_valid & id_ready.
  - Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
  - Empty: id_valid=0, id_instr/id_pc hold 0.
  - Full (count==DEPTH): imem_req=0, pc_adv=0; the PC holds.
- Flush: synchronous, highest priority.
  - Next cycle count=0 and id_valid=0; a pop in the flush cycle is ignored.
  - imem_req is forced to 0 in the flush cycle, so pc_adv=0 and upstream loads the redirect target.
- imem_gnt while imem_req=0 is ignored.
- imem_rvalid in IDLE (protocol error) is ignored; no push.
- Reset mid-operation: all state cleared immediately. A later response arrives in IDLE and is ignored.

Optional Feature:
- FETCH_BYPASS_EN defined:
  - When the queue is empty, state is WAIT, imem_rvalid=1 and flush=0, the response is driven combinationally onto id_valid/id_instr/id_pc.
  - If id_ready=1 that cycle, the entry is consumed and not written; otherwise it is pushed as normal.
  - Latency becomes pc_adv at N → id_valid at N+1.
- Undefined: no bypass; id outputs come from FIFO registers only (latency N+2).

Test Plan:
- Reset then release; pc_i=0x0C00, gnt=1, rvalid one cycle after gnt with rdata=0x2008_0005, id_ready=1 -> pc_adv high in cycle 1; id_valid=1 with id_pc=0x0C00, id_instr=0x2008_0005 two cycles later.
- id_ready=0, DEPTH=2, back-to-back fetches 0x0C00, 0x0C01 -> count reaches 2; imem_req=0 and pc_adv=0 while full; raising id_ready pops 0x0C00 and the next request issues.
- Flush one cycle after pc_adv for 0x0C02, rvalid arrives two cycles later with 0xDEAD_BEEF -> response dropped, id_valid stays 0, state returns to IDLE, next request uses the new pc_i=0x0C10.
- Flush in the same cycle as rvalid with the queue holding one entry -> queue empty next cycle, no push, imem_req=0 during the flush cycle.
- Assert rst low while in WAIT, release, then inject rvalid=1 -> outputs at reset values, no push, id_valid=0.
- With FETCH_BYPASS_EN, empty queue, rvalid=1 with rdata=0x0800_0C00, id_ready=1 -> id_valid=1 in the same cycle, count stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : single-outstanding instruction fetcher feeding a DEPTH-entry
// {pc, instr} FIFO to ID. Optional macro FETCH_BYPASS_EN: empty-queue bypass.
// Revision 1.0
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] pc_i,
  output logic        pc_adv,
  input  logic        flush,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [29:0] id_pc,
  input  logic        id_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [29:0]   req_pc;
  logic [29:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic fifo_valid;
  logic resp_ok;
  logic bypass;
  logic push;
  logic pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pc_adv) state_nxt = WAIT;
      WAIT: begin
        if (imem_rvalid)   state_nxt = IDLE;
        else if (flush)    state_nxt = DROP;
      end
      DROP: if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state == IDLE) && (count < FULL) && !flush && rst;
    resp_ok  = (state == WAIT) && imem_rvalid && !flush;
  end

  assign pc_adv     = imem_req & imem_gnt;
  assign imem_addr  = pc_i;
  assign fifo_valid = (count != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_ok & ~fifo_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed response consumed by ID in the same cycle never enters the FIFO.
  assign push = resp_ok & ~(bypass & id_ready);
  assign pop  = fifo_valid & id_ready & ~flush;

  always_comb begin
    id_valid = 1'b0;
    id_instr = '0;
    id_pc    = '0;
    if (fifo_valid) begin
      id_valid = 1'b1;
      id_instr = instr_mem[rptr];
      id_pc    = pc_mem[rptr];
    end else if (bypass) begin
      id_valid = 1'b1;
      id_instr = imem_rdata;
      id_pc    = req_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      req_pc <= '0;
    end else begin
      if (pc_adv) req_pc <= pc_i;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr]    <= req_pc;
      instr_mem[wptr] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : directed + scoreboard bench for fetch_queue.
// Revision 1.0
// ============================================================================
module tb_fetch_queue;

  localparam int DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic        clk;
  logic        rst;
  logic [29:0] pc_i;
  logic        pc_adv;
  logic        flush;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [29:0] id_pc;
  logic        id_ready;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_adv(pc_adv), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [61:0] sb [$];
  logic [1:0]  m_state  = IDLE;
  logic [29:0] m_req_pc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational/head outputs, advance the model.
  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdy, input logic fl, input logic [29:0] pc);
    logic        er;
    logic        ea;
    logic        byp;
    logic        hv;
    logic [61:0] head;
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    id_ready = rdy; flush = fl; pc_i = pc;
    #2;
    er  = (m_state == IDLE) && (sb.size() < DEPTH) && !fl;
    ea  = er && g;
    byp = BYP && (sb.size() == 0) && (m_state == WAIT) && rv && !fl;
    hv  = (sb.size() > 0) || byp;
    if (sb.size() > 0) head = sb[0];
    else if (byp)      head = {m_req_pc, rd};
    else               head = '0;
    chk("imem_req",  32'(imem_req),  32'(er));
    chk("pc_adv",    32'(pc_adv),    32'(ea));
    chk("imem_addr", 32'(imem_addr), 32'(pc));
    chk("id_valid",  32'(id_valid),  32'(hv));
    chk("id_pc",     32'(id_pc),     32'(head[61:32]));
    chk("id_instr",  id_instr,       head[31:0]);
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (sb.size() > 0 && rdy) void'(sb.pop_front());
      if (m_state == WAIT && rv && !(byp && rdy)) sb.push_back({m_req_pc, rd});
    end
    case (m_state)
      IDLE: if (ea) m_state = WAIT;
      WAIT: if (rv) m_state = IDLE; else if (fl) m_state = DROP;
      DROP: if (rv) m_state = IDLE;
      default: m_state = IDLE;
    endcase
    if (ea) m_req_pc = pc;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; flush = 1'b0; id_ready = 1'b1;
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr,      32'd0);
    chk("rst_id_pc",    32'(id_pc),    32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_pc_adv",   32'(pc_adv),   32'd0);
    sb.delete();
    m_state  = IDLE;
    m_req_pc = '0;
    @(posedge clk);
    #1;
    chk("rst_hold_req", 32'(imem_req), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    logic [29:0] upc;
    logic        adv_pred;
    logic        fl;
    rst = 1'b0; pc_i = '0; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    #1;
    do_reset();

    // Single fetch, 1-cycle memory latency, ID always ready.
    cyc(1, 0, 32'h0, 1, 0, 30'h0C00);
    cyc(0, 1, 32'h2008_0005, 1, 0, 30'h0C01);
    cyc(0, 0, 32'h0, 1, 0, 30'h0C01);

    // Fill the queue with ID stalled; full queue blocks requests.
    cyc(1, 0, 32'h0, 0, 0, 30'h0C00);
    cyc(1, 1, 32'hA000_0000, 0, 0, 30'h0C01);
    cyc(1, 0, 32'h0, 0, 0, 30'h0C01);
    cyc(1, 1, 32'hA000_0001, 0, 0, 30'h0C02);
    cyc(1, 0, 32'h0, 0, 0, 30'h0C02);
    cyc(1, 0, 32'h0, 1, 0, 30'h0C02);
    cyc(1, 0, 32'h0, 0, 0, 30'h0C02);

    // Flush one cycle after pc_adv; late response is dropped.
    cyc(0, 0, 32'h0, 0, 1, 30'h0C10);
    cyc(0, 0, 32'h0, 0, 0, 30'h0C10);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 30'h0C10);
    cyc(1, 0, 32'h0, 0, 0, 30'h0C10);
    cyc(0, 1, 32'h1111_0010, 0, 0, 30'h0C11);

    // Flush coincident with rvalid while the queue holds one entry.
    cyc(1, 0, 32'h0, 0, 0, 30'h0C11);
    cyc(1, 1, 32'h2222_0011, 1, 1, 30'h0C12);
    cyc(0, 0, 32'h0, 1, 0, 30'h0C12);

    // Reset while WAIT; the stale response must be ignored.
    cyc(1, 0, 32'h0, 0, 0, 30'h0C20);
    do_reset();
    cyc(0, 1, 32'h1234_5678, 0, 0, 30'h0C21);
    cyc(0, 0, 32'h0, 0, 0, 30'h0C21);

    // Empty queue, response with ID ready (bypass path when enabled).
    cyc(1, 0, 32'h0, 1, 0, 30'h0C30);
    cyc(0, 1, 32'h0800_0C00, 1, 0, 30'h0C31);
    cyc(0, 0, 32'h0, 1, 0, 30'h0C31);

    // Streaming with random ID backpressure and occasional redirects.
    upc = 30'h0C31;
    for (int i = 0; i < 60; i++) begin
      fl       = (i % 17) == 16;
      adv_pred = (m_state == IDLE) && (sb.size() < DEPTH) && !fl;
      cyc(1, m_state != IDLE, $urandom, 1'($urandom_range(0, 1)), fl, upc);
      if (fl)            upc = 30'h0C40 + 30'(i);
      else if (adv_pred) upc = upc + 30'd1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
